// File: rtl/adder_arb_pkg.sv
// Shared types for adder_arbiter: FSM state encoding and the captured-operation record.
// Optional feature macro used by the top: ADDER_ARB_WIDE_EN.
package adder_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ID_W   = 3;  // holds any requester index for NREQ up to 8

  typedef enum logic [1:0] {
    IDLE,
    EXEC_LO,
    EXEC_HI,
    RESP
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
    logic              wide;
    logic [ID_W-1:0]   id;
  } op_t;

endpackage

// File: rtl/adder_arbiter_rr.sv
// Round-robin picker: first asserted request strictly after ptr in cyclic order.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (k + ptr) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/cla_32bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module CLA_32Bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [31:0] g, p, c;
  logic [7:0]  gg, gp;
  logic [8:0]  bc;
  logic [3:0]  gn, pn;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    bc = '0;
    c  = '0;
    gn = '0;
    pn = '0;
    bc[0] = cin;
    for (int unsigned k = 0; k < 8; k++) begin
      gn = g[4*k +: 4];
      pn = p[4*k +: 4];
      gg[k] = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1]) | (pn[3] & pn[2] & pn[1] & gn[0]);
      gp[k] = &pn;
      bc[k+1] = gg[k] | (gp[k] & bc[k]);
      c[4*k +: 4] = {gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0]) | (pn[2] & pn[1] & pn[0] & bc[k]),
                     gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & bc[k]),
                     gn[0] | (pn[0] & bc[k]),
                     bc[k]};
    end
    s    = p ^ c;
    cout = bc[8];
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin shared 32-bit add/sub unit serving NREQ valid/ready requesters.
// Define ADDER_ARB_WIDE_EN for two-pass 64-bit operations (EXEC_LO then EXEC_HI).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][DATA_W-1:0] req_a,
  input  logic [NREQ-1:0][DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]             req_sub,
`ifdef ADDER_ARB_WIDE_EN
  input  logic [NREQ-1:0]             req_wide,
  input  logic [NREQ-1:0][DATA_W-1:0] req_a_hi,
  input  logic [NREQ-1:0][DATA_W-1:0] req_b_hi,
  output logic [DATA_W-1:0]           rsp_s_hi,
`endif
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IDW-1:0]              rsp_id,
  output logic [DATA_W-1:0]           rsp_s,
  output logic                        rsp_cout
);

  state_t            state, state_nxt;
  op_t               op;
  logic [IDW-1:0]    ptr, gidx;
  logic [NREQ-1:0]   grant;
  logic              any, take;
  logic [DATA_W-1:0] add_a, add_b, add_s;
  logic              add_cin, add_cout;
  logic              unused_id;
`ifdef ADDER_ARB_WIDE_EN
  logic [DATA_W-1:0] op_a_hi, op_b_hi;
`endif

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign take      = (state == IDLE) && any && !rst;
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign unused_id = ^op.id;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = EXEC_LO;
      EXEC_LO: state_nxt = op.wide ? EXEC_HI : RESP;
      EXEC_HI: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The single adder only ever sees registered operands; the high pass reuses
  // rsp_cout as its carry-in since it still holds the low-word carry.
  always_comb begin
    add_a   = op.a;
    add_b   = op.b ^ {DATA_W{op.sub}};
    add_cin = op.sub;
`ifdef ADDER_ARB_WIDE_EN
    if (state == EXEC_HI) begin
      add_a   = op_a_hi;
      add_b   = op_b_hi ^ {DATA_W{op.sub}};
      add_cin = rsp_cout;
    end
`endif
  end

  CLA_32Bit u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      ptr      <= IDW'(NREQ - 1);
      rsp_id   <= '0;
      rsp_s    <= '0;
      rsp_cout <= 1'b0;
`ifdef ADDER_ARB_WIDE_EN
      op_a_hi  <= '0;
      op_b_hi  <= '0;
      rsp_s_hi <= '0;
`endif
    end else begin
      if (take) begin
        op.a   <= req_a[gidx];
        op.b   <= req_b[gidx];
        op.sub <= req_sub[gidx];
        op.id  <= ID_W'(gidx);
        ptr    <= gidx;
`ifdef ADDER_ARB_WIDE_EN
        op.wide <= req_wide[gidx];
        op_a_hi <= req_a_hi[gidx];
        op_b_hi <= req_b_hi[gidx];
`else
        op.wide <= 1'b0;
`endif
      end
      if (state == EXEC_LO) begin
        rsp_s    <= add_s;
        rsp_cout <= add_cout;
        rsp_id   <= op.id[IDW-1:0];
`ifdef ADDER_ARB_WIDE_EN
        rsp_s_hi <= '0;
`endif
      end
`ifdef ADDER_ARB_WIDE_EN
      if (state == EXEC_HI) begin
        rsp_s_hi <= add_s;
        rsp_cout <= add_cout;
      end
`endif
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table, corner sequences, and a
// randomized run against a spec-level reference model (wide case under ADDER_ARB_WIDE_EN).
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready, req_sub;
  logic [NREQ-1:0][31:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready, rsp_cout;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_s;
`ifdef ADDER_ARB_WIDE_EN
  logic [NREQ-1:0]       req_wide;
  logic [NREQ-1:0][31:0] req_a_hi, req_b_hi;
  logic [31:0]           rsp_s_hi;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
`ifdef ADDER_ARB_WIDE_EN
    .req_wide  (req_wide),
    .req_a_hi  (req_a_hi),
    .req_b_hi  (req_b_hi),
    .rsp_s_hi  (rsp_s_hi),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_cout  (rsp_cout)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference arithmetic: {carry, result}; for subtract carry means "no borrow".
  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    if (sub) return {a >= b, a - b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One request on requester r with rsp_ready held high; lat counts edges from handshake to rsp_valid.
  task automatic run_single(input int r, input logic [31:0] a, input logic [31:0] b, input logic sub,
                            output logic [31:0] s, output logic c, output logic [IDW-1:0] id, output int lat);
    logic hs, got;
    rsp_ready    = 1'b1;
    req_valid[r] = 1'b1;
    req_a[r]     = a;
    req_b[r]     = b;
    req_sub[r]   = sub;
    hs = 1'b0;
    for (int w = 0; w < 20 && !hs; w++) begin
      @(negedge clk);
      hs = req_ready[r];
    end
    lat = 99;
    if (hs) begin
      tick();
      req_valid[r] = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        lat++;
        got = rsp_valid;
      end
    end
    s  = rsp_s;
    c  = rsp_cout;
    id = rsp_id;
    tick();
  endtask

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0]    s;
    logic           c;
    logic [IDW-1:0] id;
    int             lat, g, mptr, mphase, exp_g;
    logic           got;
    logic [32:0]    exp_r;
    int             exp_id;
    int             order[5];

    vecs[0] = '{0, 32'd5,          32'd7,          1'b0, 32'd12,         1'b0};
    vecs[1] = '{1, 32'd3,          32'd5,          1'b1, 32'hFFFF_FFFE,  1'b0};
    vecs[2] = '{1, 32'd5,          32'd3,          1'b1, 32'd2,          1'b1};
    vecs[3] = '{2, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b1};
    vecs[4] = '{3, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'd0,          1'b1};
    vecs[5] = '{0, 32'd0,          32'd0,          1'b1, 32'd0,          1'b1};
    vecs[6] = '{2, 32'd0,          32'd1,          1'b1, 32'hFFFF_FFFF,  1'b0};
    vecs[7] = '{3, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b0};
    order   = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    rsp_ready = 1'b0;
`ifdef ADDER_ARB_WIDE_EN
    req_wide = '0;
    req_a_hi = '0;
    req_b_hi = '0;
`endif
    tick();
    tick();

    // Reset state, with every requester asserting valid while rst is high.
    req_valid = '1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_single(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].sub, s, c, id, lat);
      chk($sformatf("vec%0d_s", i), s, vecs[i].s);
      chk($sformatf("vec%0d_cout", i), c, vecs[i].c);
      chk($sformatf("vec%0d_id", i), id, vecs[i].r);
      chk($sformatf("vec%0d_lat", i), lat, 2);
    end

    // All requesters held valid: grants rotate 0,1,2,3,0.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 32'(i * 100 + 1);
      req_b[i] = 32'(i);
      req_sub[i] = 1'b0;
    end
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        got = |req_ready;
      end
      g = onehot_idx(req_ready);
      chk($sformatf("rr_order%0d", n), g, order[n]);
      tick();
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        got = rsp_valid;
      end
      chk($sformatf("rr_id%0d", n), rsp_id, order[n]);
      chk($sformatf("rr_s%0d", n), rsp_s, order[n] * 101 + 1);
      tick();
    end

    // Response back-pressure: outputs frozen, no grants while RESP is held.
    do_reset();
    rsp_ready = 1'b0;
    req_a[0] = 32'h1234_0000; req_b[0] = 32'h0000_5678; req_sub[0] = 1'b0;
    req_a[2] = 32'd10;        req_b[2] = 32'd20;        req_sub[2] = 1'b1;
    req_valid = 4'b0101;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk("bp_first_valid", got, 1);
    for (int n = 0; n < 5; n++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_s", rsp_s, 32'h1234_5678);
      chk("bp_id", rsp_id, 0);
      chk("bp_cout", rsp_cout, 0);
      chk("bp_req_ready", req_ready, '0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk("bp_sub_s", rsp_s, 32'hFFFF_FFF6);
    chk("bp_sub_id", rsp_id, 2);
    tick();

    // Reset during EXEC_LO discards requester 1's op and restores pointer priority to 0.
    do_reset();
    rsp_ready = 1'b1;
    req_a[1] = 32'd77; req_b[1] = 32'd1; req_sub[1] = 1'b0;
    req_a[0] = 32'd40; req_b[0] = 32'd2; req_sub[0] = 1'b0;
    req_valid = 4'b0010;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = req_ready[1];
    end
    tick();
    rst = 1'b1;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("rstx_req_ready", req_ready, '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstx_rsp_valid", rsp_valid, 0);
    chk("rstx_rsp_s", rsp_s, 0);
    chk("rstx_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk("rstx_id", rsp_id, 0);
    chk("rstx_s", rsp_s, 42);
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    mptr = NREQ - 1;
    mphase = 0;
    exp_r = '0;
    exp_id = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_g = -1;
      @(negedge clk);
      if (mphase == 0) begin
        for (int k = 1; k <= NREQ; k++)
          if (exp_g < 0 && req_valid[(mptr + k) % NREQ]) exp_g = (mptr + k) % NREQ;
        chk("rnd_grant", req_ready, (exp_g < 0) ? 0 : (1 << exp_g));
        chk("rnd_idle_valid", rsp_valid, 0);
        if (exp_g >= 0) begin
          exp_r  = ref_op(req_a[exp_g], req_b[exp_g], req_sub[exp_g]);
          exp_id = exp_g;
          mptr   = exp_g;
          mphase = 1;
        end
      end else if (mphase == 1) begin
        chk("rnd_exec_valid", rsp_valid, 0);
        chk("rnd_exec_ready", req_ready, '0);
        mphase = 2;
      end else begin
        chk("rnd_rsp_valid", rsp_valid, 1);
        chk("rnd_rsp_s", rsp_s, exp_r[31:0]);
        chk("rnd_rsp_cout", rsp_cout, exp_r[32]);
        chk("rnd_rsp_id", rsp_id, exp_id);
        chk("rnd_rsp_ready", req_ready, '0);
        if (rsp_ready) mphase = 0;
      end
      tick();
      if (exp_g >= 0) req_valid[exp_g] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_a[i]     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
          req_b[i]     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
          req_sub[i]   = 1'($urandom_range(0, 1));
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    req_valid = '0;

`ifdef ADDER_ARB_WIDE_EN
    // 64-bit: 0x00000000_FFFFFFFF + 1 carries into the high word.
    do_reset();
    req_wide[0] = 1'b1;
    req_a_hi[0] = 32'd0;
    req_b_hi[0] = 32'd0;
    run_single(0, 32'hFFFF_FFFF, 32'd1, 1'b0, s, c, id, lat);
    chk("wide_s", s, 0);
    chk("wide_s_hi", rsp_s_hi, 1);
    chk("wide_cout", c, 0);
    chk("wide_lat", lat, 3);
    req_wide[0] = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
